// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It issues one instruction-memory read at a time
//   and holds the returned word in an output register for decode. A redirect
//   (branch/jump) flushes the output register and any read still in flight.
//
//   Ports
//     clk              single clock, rising edge
//     rst_n            asynchronous active-low reset
//     pc_sel[1:0]      next-pc select. The encoding matches common::pc_sel_t:
//                      PCNEXT=0, BRANCH=1, JAL=2, JALR=3. Any value other
//                      than PCNEXT is a redirect.
//     target_pc[31:0]  redirect address (only looked at during a redirect)
//     imem_req         read request, accepted in the cycle it is high
//     imem_addr[31:0]  read address (the current pc)
//     imem_rvalid      read data valid
//     imem_rdata[31:0] read data
//     if_valid         output register holds an instruction for decode
//     if_instr[31:0]   instruction for decode (BUBBLE while if_valid is low)
//     if_pc[31:0]      address of if_instr
//     id_ready         decode accepts this cycle
//     fetch_misaligned pulse on a misaligned redirect
//
//   Build option
//     FETCH_MISALIGN_CHECK_EN  defined: a redirect whose target is not word
//                              aligned raises fetch_misaligned in that cycle,
//                              flushes, and keeps the old pc.
//                              undefined: the target is forced to word
//                              alignment and fetch_misaligned is tied low.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] target_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_misaligned
);

    localparam logic [1:0]  PC_SEL_PCNEXT = 2'd0;
    localparam logic [31:0] BUBBLE        = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n_s;
    logic [31:0] pc_r;
    logic [31:0] pc_n_s;
    logic        if_valid_r;
    logic        if_valid_n_s;
    logic [31:0] if_instr_r;
    logic [31:0] if_instr_n_s;
    logic [31:0] if_pc_r;
    logic [31:0] if_pc_n_s;
    logic        redirect_s;
    logic        transfer_s;
    logic        imem_req_s;

    assign redirect_s = (pc_sel != PC_SEL_PCNEXT);
    assign transfer_s = if_valid_r && id_ready;

    // A new read goes out only when no redirect is pending and the output
    // register will be free by the time the data comes back.
    assign imem_req_s = (state_r == ST_REQ) && !redirect_s && (!if_valid_r || id_ready);

    assign imem_req  = imem_req_s;
    assign imem_addr = pc_r;
    assign if_valid  = if_valid_r;
    assign if_instr  = if_instr_r;
    assign if_pc     = if_pc_r;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misalignment is flagged in the redirect cycle itself; held low in reset.
    assign fetch_misaligned = rst_n && redirect_s && (target_pc[1:0] != 2'b00);
`else
    assign fetch_misaligned = 1'b0;
`endif

    // Next-state, next-pc and output-register logic; redirect wins over all.
    always_comb begin
        state_n_s    = state_r;
        pc_n_s       = pc_r;
        if_valid_n_s = if_valid_r;
        if_instr_n_s = if_instr_r;
        if_pc_n_s    = if_pc_r;

        if (redirect_s) begin
            if_valid_n_s = 1'b0;
            if_instr_n_s = BUBBLE;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (target_pc[1:0] != 2'b00) begin
                pc_n_s = pc_r;             // resume at the old pc
            end else begin
                pc_n_s = target_pc;
            end
`else
            pc_n_s = target_pc & 32'hFFFF_FFFC;
`endif
            case (state_r)
                ST_REQ:     state_n_s = ST_REQ;
                // Data arriving now is simply dropped; otherwise the read
                // still in flight must be swallowed in DISCARD.
                ST_WAIT:    state_n_s = imem_rvalid ? ST_REQ : ST_DISCARD;
                ST_DISCARD: state_n_s = ST_DISCARD;
                default:    state_n_s = ST_REQ;
            endcase
        end else begin
            if (transfer_s) begin
                if_valid_n_s = 1'b0;
                if_instr_n_s = BUBBLE;
            end else begin
                if_valid_n_s = if_valid_r;
                if_instr_n_s = if_instr_r;
            end
            case (state_r)
                ST_REQ: begin
                    // imem_rvalid here belongs to no request of ours.
                    if (imem_req_s) begin
                        state_n_s = ST_WAIT;
                    end else begin
                        state_n_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if_valid_n_s = 1'b1;
                        if_instr_n_s = imem_rdata;
                        if_pc_n_s    = pc_r;
                        pc_n_s       = pc_r + 32'd4;
                        state_n_s    = ST_REQ;
                    end else begin
                        state_n_s    = ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rvalid) begin
                        state_n_s = ST_REQ;
                    end else begin
                        state_n_s = ST_DISCARD;
                    end
                end
                default: state_n_s = ST_REQ;
            endcase
        end
    end

    // State, pc and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_REQ;
            pc_r       <= RESET_PC;
            if_valid_r <= 1'b0;
            if_instr_r <= BUBBLE;
            if_pc_r    <= 32'h0000_0000;
        end else begin
            state_r    <= state_n_s;
            pc_r       <= pc_n_s;
            if_valid_r <= if_valid_n_s;
            if_instr_r <= if_instr_n_s;
            if_pc_r    <= if_pc_n_s;
        end
    end

endmodule
